adc_capture_sequencer: RTL and testbench

Sequencer sitting between the Giraffe_ADC top-level and the SAR ADC pins: it generates the divided ADC clock, steps the ADC through reset, optional calibration and a fixed-length conversion burst, and captures each conversion word on adc_ack. Captured samples leave through a single-entry valid/ready register feeding the UART framer (tx2M path). LED status reflects the sequencer state.

---
 rtl/adc_capture_sequencer_if.sv | 21 ++
 rtl/adc_capture_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_adc_capture_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_capture_sequencer_if.sv
// adc_capture_sequencer_if: captured-sample stream towards the UART framer.
// Single-entry valid/ready handshake; master = sequencer, slave = consumer.
interface adc_capture_sequencer_if #(
    parameter int unsigned N_bit = 6
) ();
    logic [N_bit-1:0] smp_data;
    logic             smp_valid;
    logic             smp_ready;

    modport master (
        output smp_data,
        output smp_valid,
        input  smp_ready
    );

    modport slave (
        input  smp_data,
        input  smp_valid,
        output smp_ready
    );
endinterface

// File: rtl/adc_capture_sequencer.sv
// adc_capture_sequencer: generates the divided ADC clock, steps the SAR ADC
// through reset, optional calibration and a fixed-length conversion burst,
// and captures each conversion word into a single-entry valid/ready register.
// Optional watchdog in CALIB/SAMPLE: define ADC_SEQ_TIMEOUT_EN.
module adc_capture_sequencer #(
    parameter int unsigned N_bit       = 6,
    parameter int unsigned NUM_DIV     = 1,
    parameter int unsigned NUM_Sampled = 32,
    parameter int unsigned RST_CYC     = 16,
    parameter int unsigned CALIB_ACKS  = 64,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                    clk_50M,
    input  logic                    nrst,
    input  logic                    start,
    input  logic                    calib_ena_FPGA,
    input  logic                    adc_ack,
    input  logic                    adc_ack_sub,
    input  logic [N_bit-1:0]        dout_adc,
    output logic                    rstn_adc,
    output logic                    clk_adc,
    output logic                    calib_ena_adc,
    output logic                    adc_ena,
    output logic                    busy,
    output logic                    timeout,
    output logic [3:0]              LED_out,
    adc_capture_sequencer_if.master smp
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADC_RST = 3'd1,
        CALIB   = 3'd2,
        SAMPLE  = 3'd3,
        DONE    = 3'd4
    } state_t;

    // One shared phase counter: ADC_RST cycles, CALIB sub-edges, SAMPLE captures.
    localparam int unsigned CNT_MAX_A = (RST_CYC > CALIB_ACKS) ? RST_CYC : CALIB_ACKS;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > NUM_Sampled) ? CNT_MAX_A : NUM_Sampled;
    localparam int unsigned CW        = $clog2(CNT_MAX + 1);
    localparam int unsigned DW        = $clog2(NUM_DIV + 1);

    localparam logic [CW-1:0] RST_LAST   = CW'(RST_CYC - 1);
    localparam logic [CW-1:0] CALIB_LAST = CW'(CALIB_ACKS - 1);
    localparam logic [CW-1:0] SMP_LAST   = CW'(NUM_Sampled - 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(NUM_DIV - 1);

    if (N_bit < 1 || NUM_DIV < 1 || NUM_Sampled < 1 || RST_CYC < 1 ||
        CALIB_ACKS < 1 || TIMEOUT_CYC < 1) begin : g_bad_params
        $error("adc_capture_sequencer: size parameters must all be >= 1");
    end

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]    div_q;
    logic             calib_q, calib_d;
    logic             ack_q, sub_q;
    logic             ack_edge, sub_edge, capture;
    logic [N_bit-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             rstn_adc_q, clk_adc_q, calib_ena_adc_q, adc_ena_q, busy_q;

`ifdef ADC_SEQ_TIMEOUT_EN
    localparam int unsigned   WW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYC - 1);
    logic [WW-1:0] wd_q, wd_d;
    logic          timeout_q, timeout_d;
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    // Strobes come from the clk_adc domain, itself derived from clk_50M, so a
    // single registered copy is enough for rising-edge detection.
    assign ack_edge = adc_ack & ~ack_q;
    assign sub_edge = adc_ack_sub & ~sub_q;

    // Next-state, phase counter, watchdog and output-register decisions.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        calib_d   = calib_q;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        capture   = 1'b0;
`ifdef ADC_SEQ_TIMEOUT_EN
        // Watchdog restarts from zero on every state entry and on any cycle
        // that does not explicitly keep it counting.
        wd_d      = '0;
        timeout_d = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = ADC_RST;
                    cnt_d     = '0;
                    calib_d   = calib_ena_FPGA;
                    overrun_d = 1'b0;
`ifdef ADC_SEQ_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                end
            end
            ADC_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = calib_q ? CALIB : SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CALIB: begin
                if (sub_edge) begin
                    if (cnt_q == CALIB_LAST) begin
                        state_d = SAMPLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef ADC_SEQ_TIMEOUT_EN
                else if (wd_q == WD_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            SAMPLE: begin
                if (ack_edge) begin
                    capture = 1'b1;
                    if (cnt_q == SMP_LAST) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef ADC_SEQ_TIMEOUT_EN
                else if (wd_q == WD_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            DONE: begin
                if (!valid_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Transfer first, so a capture in the same cycle sees a free slot.
        if (valid_q && smp.smp_ready) begin
            valid_d = 1'b0;
        end
        if (capture) begin
            if (!valid_q || smp.smp_ready) begin
                data_d  = dout_adc;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // State, counters, clock divider and registered ADC/status outputs.
    always_ff @(posedge clk_50M) begin
        if (!nrst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            div_q           <= '0;
            calib_q         <= 1'b0;
            ack_q           <= 1'b0;
            sub_q           <= 1'b0;
            data_q          <= '0;
            valid_q         <= 1'b0;
            overrun_q       <= 1'b0;
            rstn_adc_q      <= 1'b0;
            clk_adc_q       <= 1'b0;
            calib_ena_adc_q <= 1'b0;
            adc_ena_q       <= 1'b0;
            busy_q          <= 1'b0;
`ifdef ADC_SEQ_TIMEOUT_EN
            wd_q            <= '0;
            timeout_q       <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            calib_q         <= calib_d;
            ack_q           <= adc_ack;
            sub_q           <= adc_ack_sub;
            data_q          <= data_d;
            valid_q         <= valid_d;
            overrun_q       <= overrun_d;
            rstn_adc_q      <= (state_d == CALIB) || (state_d == SAMPLE) || (state_d == DONE);
            calib_ena_adc_q <= (state_d == CALIB);
            adc_ena_q       <= (state_d == SAMPLE);
            busy_q          <= (state_d != IDLE);
`ifdef ADC_SEQ_TIMEOUT_EN
            wd_q            <= wd_d;
            timeout_q       <= timeout_d;
`endif
            // Divider is held clear in IDLE and on the ADC_RST entry edge, so
            // the first clk_adc rise lands NUM_DIV cycles after entry.
            if (state_d == IDLE || state_q == IDLE) begin
                div_q     <= '0;
                clk_adc_q <= 1'b0;
            end else if (div_q == DIV_LAST) begin
                div_q     <= '0;
                clk_adc_q <= ~clk_adc_q;
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

    assign rstn_adc      = rstn_adc_q;
    assign clk_adc       = clk_adc_q;
    assign calib_ena_adc = calib_ena_adc_q;
    assign adc_ena       = adc_ena_q;
    assign busy          = busy_q;
    assign LED_out       = {overrun_q, state_q};
    assign smp.smp_data  = data_q;
    assign smp.smp_valid = valid_q;

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// tb_adc_capture_sequencer: directed self-checking bench for the ADC sequencer.
// Table-driven backpressure vectors plus hand-written multi-cycle sequences.
module tb_adc_capture_sequencer;

    logic       clk_50M = 1'b0;
    logic       nrst;
    logic       start;
    logic       calib_ena_FPGA;
    logic       adc_ack;
    logic       adc_ack_sub;
    logic [5:0] dout_adc;
    logic       rstn_adc;
    logic       clk_adc;
    logic       calib_ena_adc;
    logic       adc_ena;
    logic       busy;
    logic       timeout;
    logic [3:0] LED_out;

    int checks = 0;
    int errors = 0;

    adc_capture_sequencer_if #(.N_bit(6)) smp_if ();

    adc_capture_sequencer #(
        .N_bit      (6),
        .NUM_DIV    (1),
        .NUM_Sampled(32),
        .RST_CYC    (16),
        .CALIB_ACKS (4),
        .TIMEOUT_CYC(4096)
    ) dut (
        .clk_50M       (clk_50M),
        .nrst          (nrst),
        .start         (start),
        .calib_ena_FPGA(calib_ena_FPGA),
        .adc_ack       (adc_ack),
        .adc_ack_sub   (adc_ack_sub),
        .dout_adc      (dout_adc),
        .rstn_adc      (rstn_adc),
        .clk_adc       (clk_adc),
        .calib_ena_adc (calib_ena_adc),
        .adc_ena       (adc_ena),
        .busy          (busy),
        .timeout       (timeout),
        .LED_out       (LED_out),
        .smp           (smp_if)
    );

    always #5 clk_50M = ~clk_50M;

    typedef struct {
        logic       ack;
        logic [5:0] dout;
        logic       rdy;
        logic       st;
        logic       exp_v;
        logic [5:0] exp_d;
        logic [3:0] exp_led;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rstn_adc"}, rstn_adc, 0);
        check({tag, "_clk_adc"}, clk_adc, 0);
        check({tag, "_calib_ena_adc"}, calib_ena_adc, 0);
        check({tag, "_adc_ena"}, adc_ena, 0);
        check({tag, "_smp_data"}, smp_if.smp_data, 0);
        check({tag, "_smp_valid"}, smp_if.smp_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_LED"}, LED_out, 0);
    endtask

    task automatic wait_code(input logic [2:0] code, input int bound, input string tag);
        int n = 0;
        while (LED_out[2:0] != code && n < bound) begin
            tick();
            n++;
        end
        check({tag, "_wait_state"}, LED_out[2:0], code);
    endtask

    task automatic run_samples(input int n, input int base, input int gap, input string tag);
        logic [5:0] d;
        for (int i = 0; i < n; i++) begin
            d        = 6'(base + i);
            adc_ack  = 1'b1;
            dout_adc = d;
            tick();
            check({tag, "_valid"}, smp_if.smp_valid, 1);
            check({tag, "_data"}, smp_if.smp_data, d);
            adc_ack = 1'b0;
            repeat (gap) tick();
        end
    endtask

    initial begin
        int n;
        int bad_clk;

        vecs[0] = '{1'b1, 6'h05, 1'b0, 1'b0, 1'b1, 6'h05, 4'h3};
        vecs[1] = '{1'b0, 6'h00, 1'b0, 1'b0, 1'b1, 6'h05, 4'h3};
        vecs[2] = '{1'b1, 6'h0C, 1'b1, 1'b0, 1'b1, 6'h0C, 4'h3};
        vecs[3] = '{1'b0, 6'h00, 1'b0, 1'b1, 1'b1, 6'h0C, 4'h3};
        vecs[4] = '{1'b1, 6'h15, 1'b1, 1'b0, 1'b1, 6'h15, 4'h3};
        vecs[5] = '{1'b0, 6'h00, 1'b0, 1'b0, 1'b1, 6'h15, 4'h3};
        vecs[6] = '{1'b1, 6'h2A, 1'b0, 1'b0, 1'b1, 6'h15, 4'hB};
        vecs[7] = '{1'b0, 6'h00, 1'b0, 1'b0, 1'b1, 6'h15, 4'hB};
        vecs[8] = '{1'b0, 6'h00, 1'b1, 1'b0, 1'b0, 6'h15, 4'hB};
        vecs[9] = '{1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 6'h15, 4'hB};

        nrst             = 1'b0;
        start            = 1'b0;
        calib_ena_FPGA   = 1'b0;
        adc_ack          = 1'b0;
        adc_ack_sub      = 1'b0;
        dout_adc         = '0;
        smp_if.smp_ready = 1'b1;

        // Power-on reset
        repeat (3) tick();
        check_reset_vals("por");
        nrst = 1'b1;
        tick();
        check("por_idle_LED", LED_out, 0);

        // Run A: no calibration, ADC reset length, clk_adc phase, 32 samples
        start = 1'b1;
        tick();
        start = 1'b0;
        check("A_busy", busy, 1);
        check("A_LED_rst", LED_out, 4'h1);
        n = 0;
        bad_clk = 0;
        while (rstn_adc == 1'b0 && n < 100) begin
            if (clk_adc != 1'((n % 2))) bad_clk++;
            tick();
            n++;
        end
        check("A_rstn_low_cycles", n, 16);
        check("A_clk_adc_phase_errs", bad_clk, 0);
        check("A_LED_sample", LED_out, 4'h3);
        check("A_adc_ena", adc_ena, 1);
        check("A_calib_ena_adc", calib_ena_adc, 0);
        run_samples(31, 0, 79, "A");
        check("A_still_sample", LED_out, 4'h3);
        adc_ack  = 1'b1;
        dout_adc = 6'd31;
        tick();
        adc_ack = 1'b0;
        check("A_last_data", smp_if.smp_data, 31);
        check("A_last_valid", smp_if.smp_valid, 1);
        check("A_LED_done", LED_out, 4'h4);
        check("A_done_adc_ena", adc_ena, 0);
        check("A_done_rstn", rstn_adc, 1);
        tick();
        check("A_done_drained", smp_if.smp_valid, 0);
        check("A_done_hold", LED_out, 4'h4);
        tick();
        check("A_idle_LED", LED_out, 4'h0);
        check("A_idle_busy", busy, 0);
        check("A_idle_rstn", rstn_adc, 0);
        check("A_idle_clk_adc", clk_adc, 0);

        // Run B: calibration with 4 sub-acks, adc_ack ignored in CALIB
        calib_ena_FPGA = 1'b1;
        start          = 1'b1;
        tick();
        start          = 1'b0;
        calib_ena_FPGA = 1'b0;
        wait_code(3'd2, 40, "B_calib");
        check("B_calib_ena_adc", calib_ena_adc, 1);
        check("B_calib_rstn", rstn_adc, 1);
        check("B_calib_adc_ena", adc_ena, 0);
        adc_ack  = 1'b1;
        dout_adc = 6'h3F;
        tick();
        adc_ack = 1'b0;
        tick();
        check("B_calib_no_capture_v", smp_if.smp_valid, 0);
        check("B_calib_no_capture_d", smp_if.smp_data, 31);
        for (int i = 0; i < 4; i++) begin
            adc_ack_sub = 1'b1;
            tick();
            adc_ack_sub = 1'b0;
            if (i < 3) begin
                check("B_sub_still_calib", LED_out, 4'h2);
                check("B_sub_calib_ena", calib_ena_adc, 1);
            end else begin
                check("B_sub_to_sample", LED_out, 4'h3);
                check("B_sub_calib_off", calib_ena_adc, 0);
                check("B_sub_adc_ena", adc_ena, 1);
            end
            repeat (19) tick();
        end
        adc_ack_sub = 1'b1;
        tick();
        adc_ack_sub = 1'b0;
        tick();
        check("B_sub_ignored_state", LED_out, 4'h3);
        check("B_sub_ignored_valid", smp_if.smp_valid, 0);
        run_samples(32, 0, 10, "B");
        check("B_end_LED", LED_out, 4'h0);
        check("B_end_busy", busy, 0);

        // Run C: reset asserted mid-SAMPLE with a word held
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_code(3'd3, 40, "C");
        run_samples(3, 1, 4, "C");
        smp_if.smp_ready = 1'b0;
        adc_ack          = 1'b1;
        dout_adc         = 6'h05;
        tick();
        adc_ack = 1'b0;
        check("C_held_valid", smp_if.smp_valid, 1);
        nrst = 1'b0;
        tick();
        check_reset_vals("C_rst");
        tick();
        nrst             = 1'b1;
        smp_if.smp_ready = 1'b1;
        tick();
        check("C_after_rst_LED", LED_out, 4'h0);

        // Run D: backpressure/overrun vectors, start while busy, DONE waits
        smp_if.smp_ready = 1'b0;
        start            = 1'b1;
        tick();
        start = 1'b0;
        wait_code(3'd3, 40, "D");
        for (int i = 0; i < 10; i++) begin
            adc_ack          = vecs[i].ack;
            dout_adc         = vecs[i].dout;
            smp_if.smp_ready = vecs[i].rdy;
            start            = vecs[i].st;
            tick();
            check($sformatf("D_vec%0d_valid", i), smp_if.smp_valid, vecs[i].exp_v);
            check($sformatf("D_vec%0d_data", i), smp_if.smp_data, vecs[i].exp_d);
            check($sformatf("D_vec%0d_LED", i), LED_out, vecs[i].exp_led);
        end
        start            = 1'b0;
        adc_ack          = 1'b0;
        smp_if.smp_ready = 1'b1;
        tick();
        run_samples(27, 32, 4, "D");
        check("D_31_still_sample", LED_out, 4'hB);
        smp_if.smp_ready = 1'b0;
        adc_ack          = 1'b1;
        dout_adc         = 6'h3E;
        tick();
        adc_ack = 1'b0;
        check("D_last_LED", LED_out, 4'hC);
        check("D_last_data", smp_if.smp_data, 6'h3E);
        repeat (5) tick();
        check("D_done_waits", LED_out, 4'hC);
        check("D_done_valid", smp_if.smp_valid, 1);
        smp_if.smp_ready = 1'b1;
        tick();
        check("D_done_drain", LED_out, 4'hC);
        tick();
        check("D_idle_LED", LED_out, 4'h8);
        check("D_idle_busy", busy, 0);

        // Run E: next start clears overrun; watchdog behaviour depends on build
        start = 1'b1;
        tick();
        start = 1'b0;
        check("E_overrun_cleared", LED_out, 4'h1);
        wait_code(3'd3, 40, "E");
`ifdef ADC_SEQ_TIMEOUT_EN
        n = 0;
        while (busy && n < 5000) begin
            tick();
            n++;
        end
        check("E_timeout_cycles", n, 4096);
        check("E_timeout_flag", timeout, 1);
        check("E_timeout_LED", LED_out, 4'h0);
        check("E_timeout_valid", smp_if.smp_valid, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("E_timeout_cleared", timeout, 0);
        check("E_restart_LED", LED_out, 4'h1);
`else
        repeat (300) tick();
        check("E_waits_in_sample", LED_out, 4'h3);
        check("E_no_timeout", timeout, 0);
`endif
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        check("E_final_reset_LED", LED_out, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
